// File: rtl/alu_nibble_sequencer.sv
// Serial controller driving one 4-bit 74181-style slice across WIDTH-bit operands, LSB nibble first.
// Optional op_count output (saturating 16-bit completed-op counter) enabled by defining ALU_OP_COUNT_EN.
module alu_nibble_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [3:0]       req_s,
    input  logic             req_m,
    input  logic             req_c_in,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [3:0]       alu_s,
    output logic             alu_m,
    output logic             alu_c_in,
    input  logic [3:0]       alu_f,
    input  logic             alu_c_out,
    input  logic             alu_a_eq_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_f,
    output logic             res_c_out,
    output logic             res_a_eq_b,
`ifdef ALU_OP_COUNT_EN
    output logic [15:0]      op_count,
`endif
    output logic             res_zero
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   a_lat;
    logic [WIDTH-1:0]   b_lat;
    logic [3:0]         s_lat;
    logic               m_lat;
    logic               c_in_lat;
    logic [IDX_W-1:0]   idx;
    logic               carry;
    logic               eq_acc;
    logic [WIDTH-1:0]   f_acc;
    logic               res_active;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a_lat    <= '0;
            b_lat    <= '0;
            s_lat    <= '0;
            m_lat    <= 1'b0;
            c_in_lat <= 1'b0;
            idx      <= '0;
            carry    <= 1'b0;
            eq_acc   <= 1'b0;
            f_acc    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        a_lat    <= req_a;
                        b_lat    <= req_b;
                        s_lat    <= req_s;
                        m_lat    <= req_m;
                        c_in_lat <= req_c_in;
                        idx      <= '0;
                        carry    <= 1'b0;
                        eq_acc   <= 1'b1;
                        f_acc    <= '0;
                    end
                end
                RUN: begin
                    f_acc[{idx, 2'b00} +: 4] <= alu_f;
                    carry  <= alu_c_out;
                    eq_acc <= eq_acc & alu_a_eq_b;
                    idx    <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Slice inputs come only from registers, so alu_* results never reach an output combinationally.
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        res_active = 1'b0;
        alu_a      = '0;
        alu_b      = '0;
        alu_s      = '0;
        alu_m      = 1'b0;
        alu_c_in   = 1'b0;
        case (state)
            IDLE:    if (req_valid) state_nxt = RUN;
            RUN:     if (idx == LAST_IDX) state_nxt = DONE;
            DONE:    if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (!rst) begin
            alu_s = s_lat;
            alu_m = m_lat;
            case (state)
                IDLE: req_ready = 1'b1;
                RUN: begin
                    alu_a    = a_lat[{idx, 2'b00} +: 4];
                    alu_b    = b_lat[{idx, 2'b00} +: 4];
                    alu_c_in = (idx == '0) ? c_in_lat : carry;
                end
                DONE:    res_active = 1'b1;
                default: ;
            endcase
        end
    end

    assign res_valid  = res_active;
    assign res_f      = res_active ? f_acc : '0;
    assign res_c_out  = res_active & carry;
    assign res_a_eq_b = res_active & eq_acc;
    assign res_zero   = res_active & (f_acc == '0);

`ifdef ALU_OP_COUNT_EN
    logic [15:0] op_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            op_cnt <= '0;
        end else if (state == DONE && res_ready && op_cnt != '1) begin
            op_cnt <= op_cnt + 16'd1;
        end
    end

    assign op_count = rst ? '0 : op_cnt;
`endif

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Directed bench for alu_nibble_sequencer with a behavioural 74181 slice (active-high data, active-low carry).
module tb_alu_nibble_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic [3:0] req_s;
    logic       req_m;
    logic       req_c_in;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_s;
    logic       alu_m;
    logic       alu_c_in;
    logic [3:0] alu_f;
    logic       alu_c_out;
    logic       alu_a_eq_b;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_f;
    logic       res_c_out;
    logic       res_a_eq_b;
    logic       res_zero;
`ifdef ALU_OP_COUNT_EN
    logic [15:0] op_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_nibble_sequencer #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_s(req_s), .req_m(req_m), .req_c_in(req_c_in),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_c_in(alu_c_in),
        .alu_f(alu_f), .alu_c_out(alu_c_out), .alu_a_eq_b(alu_a_eq_b),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_f(res_f), .res_c_out(res_c_out), .res_a_eq_b(res_a_eq_b),
`ifdef ALU_OP_COUNT_EN
        .op_count(op_count),
`endif
        .res_zero(res_zero)
    );

    // 74181 slice: returns {a_eq_b, c_out, f}; carry in/out are active-low.
    function automatic logic [5:0] slice(input logic [3:0] a, input logic [3:0] b,
                                         input logic [3:0] s, input logic m, input logic cn);
        logic [3:0] f;
        logic e, d, cb;
        cb = cn;
        for (int i = 0; i < 4; i++) begin
            e    = ~((a[i] & b[i] & s[3]) | (a[i] & ~b[i] & s[2]));
            d    = ~(a[i] | (b[i] & s[0]) | (~b[i] & s[1]));
            f[i] = (e ^ d) ^ ~(~m & cb);
            cb   = ~(~e | (~d & ~cb));
        end
        return {&f, cb, f};
    endfunction

    always_comb {alu_a_eq_b, alu_c_out, alu_f} = slice(alu_a, alu_b, alu_s, alu_m, alu_c_in);

    task automatic send_req(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s,
                            input logic m, input logic c);
        @(negedge clk);
        req_a = a; req_b = b; req_s = s; req_m = m; req_c_in = c; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        req_a = 8'hFF; req_b = 8'hFF; req_s = 4'h0; req_m = ~m; req_c_in = ~c;
    endtask

    task automatic finish_res;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if ({req_ready, res_valid, res_f, res_c_out, res_a_eq_b, res_zero, alu_a, alu_b, alu_s, alu_m, alu_c_in} !== '0) begin
            errors++;
            $display("FAIL reset_outputs_zero: req_ready=%b res_valid=%b res_f=%h alu_s=%h", req_ready, res_valid, res_f, alu_s);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || res_valid !== 1'b0 || res_f !== 8'h00) begin
            errors++;
            $display("FAIL reset_idle: req_ready=%b res_valid=%b res_f=%h expected 1 0 00", req_ready, res_valid, res_f);
        end
    endtask

    task automatic test_add;
        send_req(8'h4C, 8'h37, 4'b1001, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (alu_a !== 4'hC || alu_b !== 4'h7 || alu_c_in !== 1'b1 || alu_f !== 4'h3 || alu_c_out !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL add_low_pass: a=%h b=%h cin=%b f=%h cout=%b ready=%b expected C 7 1 3 0 0", alu_a, alu_b, alu_c_in, alu_f, alu_c_out, req_ready);
        end
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_latency_early1: res_valid=%b expected 0", res_valid);
        end
        @(negedge clk);
        checks++;
        if (alu_a !== 4'h4 || alu_b !== 4'h3 || alu_c_in !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_high_pass: a=%h b=%h cin=%b res_valid=%b expected 4 3 0 0", alu_a, alu_b, alu_c_in, res_valid);
        end
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b1 || res_f !== 8'h83 || res_c_out !== 1'b1 || res_zero !== 1'b0) begin
            errors++;
            $display("FAIL add_result: valid=%b f=%h cout=%b zero=%b expected 1 83 1 0", res_valid, res_f, res_c_out, res_zero);
        end
        checks++;
        if (alu_a !== 4'h0 || alu_b !== 4'h0 || alu_c_in !== 1'b0 || alu_s !== 4'b1001 || alu_m !== 1'b0) begin
            errors++;
            $display("FAIL add_slice_idle: a=%h b=%h cin=%b s=%h m=%b expected 0 0 0 9 0", alu_a, alu_b, alu_c_in, alu_s, alu_m);
        end
        finish_res();
        checks++;
        if (res_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL add_release: res_valid=%b req_ready=%b expected 0 1", res_valid, req_ready);
        end
    endtask

    task automatic test_xor;
        send_req(8'hF0, 8'hFF, 4'b0110, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (res_valid !== 1'b1 || res_f !== 8'h0F || res_zero !== 1'b0) begin
            errors++;
            $display("FAIL xor_result: valid=%b f=%h zero=%b expected 1 0F 0", res_valid, res_f, res_zero);
        end
        finish_res();
        send_req(8'h3C, 8'h3C, 4'b0110, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (res_valid !== 1'b1 || res_f !== 8'h00 || res_zero !== 1'b1 || res_a_eq_b !== 1'b0) begin
            errors++;
            $display("FAIL xor_zero: valid=%b f=%h zero=%b eq=%b expected 1 00 1 0", res_valid, res_f, res_zero, res_a_eq_b);
        end
        finish_res();
    endtask

    task automatic test_equality;
        send_req(8'h5A, 8'h5A, 4'b0110, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        checks++;
        if (res_f !== 8'hFF || res_a_eq_b !== 1'b1 || res_c_out !== 1'b1) begin
            errors++;
            $display("FAIL eq_same: f=%h eq=%b cout=%b expected FF 1 1", res_f, res_a_eq_b, res_c_out);
        end
        finish_res();
        send_req(8'h5A, 8'h5B, 4'b0110, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        checks++;
        if (res_f !== 8'hFE || res_a_eq_b !== 1'b0) begin
            errors++;
            $display("FAIL eq_diff: f=%h eq=%b expected FE 0", res_f, res_a_eq_b);
        end
        finish_res();
    endtask

    task automatic test_backpressure;
        send_req(8'h12, 8'h34, 4'b1001, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        req_a = 8'h01; req_b = 8'h01; req_s = 4'b1001; req_m = 1'b0; req_c_in = 1'b1; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (res_valid !== 1'b1 || res_f !== 8'h46 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: valid=%b f=%h req_ready=%b expected 1 46 0", i, res_valid, res_f, req_ready);
            end
            @(negedge clk);
        end
        finish_res();
        checks++;
        if (req_ready !== 1'b1 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: req_ready=%b res_valid=%b expected 1 0", req_ready, res_valid);
        end
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_second_accept: req_ready=%b expected 0", req_ready);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (res_valid !== 1'b1 || res_f !== 8'h02) begin
            errors++;
            $display("FAIL stall_second_result: valid=%b f=%h expected 1 02", res_valid, res_f);
        end
        finish_res();
    endtask

    task automatic test_reset_mid_op;
        send_req(8'h4C, 8'h37, 4'b1001, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({req_ready, res_valid, alu_a, alu_b, alu_s, alu_m, alu_c_in} !== '0) begin
            errors++;
            $display("FAIL midop_during_rst: req_ready=%b res_valid=%b alu_a=%h alu_s=%h expected all 0", req_ready, res_valid, alu_a, alu_s);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (res_valid !== 1'b0 || req_ready !== 1'b1 || res_f !== 8'h00 || res_c_out !== 1'b0 || res_a_eq_b !== 1'b0 || res_zero !== 1'b0) begin
            errors++;
            $display("FAIL midop_idle: valid=%b ready=%b f=%h cout=%b eq=%b zero=%b expected 0 1 00 0 0 0",
                     res_valid, req_ready, res_f, res_c_out, res_a_eq_b, res_zero);
        end
        send_req(8'h4C, 8'h37, 4'b1001, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        checks++;
        if (res_valid !== 1'b1 || res_f !== 8'h83 || res_c_out !== 1'b1) begin
            errors++;
            $display("FAIL midop_recover: valid=%b f=%h cout=%b expected 1 83 1", res_valid, res_f, res_c_out);
        end
        finish_res();
    endtask

`ifdef ALU_OP_COUNT_EN
    task automatic test_op_count;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send_req(8'h11, 8'h22, 4'b1001, 1'b0, 1'b1);
            repeat (3) @(negedge clk);
            finish_res();
        end
        checks++;
        if (op_count !== 16'd3) begin
            errors++;
            $display("FAIL op_count_three: got %h expected 0003", op_count);
        end
        force dut.op_cnt = 16'hFFFF;
        #1 release dut.op_cnt;
        send_req(8'h11, 8'h22, 4'b1001, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        finish_res();
        checks++;
        if (op_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL op_count_saturate: got %h expected FFFF", op_count);
        end
    endtask
`endif

    initial begin
        rst = 1'b1; req_valid = 1'b0; res_ready = 1'b0;
        req_a = '0; req_b = '0; req_s = '0; req_m = 1'b0; req_c_in = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
        test_add();
        test_xor();
        test_equality();
        test_backpressure();
        test_reset_mid_op();
`ifdef ALU_OP_COUNT_EN
        test_op_count();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
